// File: rtl/aec_pkg.sv
// aec_pkg: shared constants and types for the AEC front-end feeder.
//   ASCII_*        : character codes of the AEC expression alphabet
//   AEC_BUFFER_LEN : character capacity of the AEC internal buffer
//   state_t        : feeder control states
package aec_pkg;

  localparam logic [7:0] ASCII_LP  = 8'd40;
  localparam logic [7:0] ASCII_RP  = 8'd41;
  localparam logic [7:0] ASCII_MUL = 8'd42;
  localparam logic [7:0] ASCII_ADD = 8'd43;
  localparam logic [7:0] ASCII_SUB = 8'd45;
  localparam logic [7:0] ASCII_EQ  = 8'd61;

  localparam int AEC_BUFFER_LEN = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_FIN = 3'd2,
    DRAIN    = 3'd3,
    OVF      = 3'd4,
    REPORT   = 3'd5
  } state_t;

endpackage

// File: rtl/aec_char_fifo.sv
// aec_char_fifo: synchronous FIFO with first-word peek.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   flush      : drop all contents (takes priority over push/pop)
//   push       : write push_data; accepted when not full, or when full and popping
//   pop        : advance past head; ignored when empty
//   head       : current first entry (valid while !empty)
//   full/empty : occupancy flags
module aec_char_fifo #(
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/aec_feeder.sv
// aec_feeder: buffers host ASCII expressions and feeds complete ones to the
// AEC core one character per cycle, then returns the AEC result.
//   in_valid/in_data/in_ready    : host character stream (ready = FIFO space)
//   aec_ready/aec_ascii          : launch strobe and character to the AEC
//   aec_finish/aec_result/aec_valid : AEC completion inputs
//   res_valid/res_ready/res_data/res_err : result handshake to the consumer
// Optional build macro AEC_FEED_LEN_CHECK_EN rejects expressions longer than
// the AEC buffer without sending them.
module aec_feeder
  import aec_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        aec_ready,
  output logic [7:0]  aec_ascii,
  input  logic        aec_finish,
  input  logic [31:0] aec_result,
  input  logic        aec_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  state_t      state;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        pop_req;
  logic        full;
  logic        empty;
  logic [7:0]  head;
  logic        head_is_eq;
  logic        push_eq;
  logic        pop_eq;
  logic        launch;
  logic [AW:0] eq_cnt;

  // In OVF the host is never stalled; its bytes are simply not stored.
  assign in_ready   = (state == OVF) || !full;
  assign fifo_push  = in_valid && in_ready && (state != OVF);
  assign fifo_flush = (state == OVF);
  assign fifo_pop   = pop_req && !empty;
  assign head_is_eq = !empty && (head == ASCII_EQ);
  assign push_eq    = fifo_push && (in_data == ASCII_EQ);
  assign pop_eq     = fifo_pop && head_is_eq;
  assign launch     = (eq_cnt != '0) && !res_valid;

  always_comb begin
    pop_req = 1'b0;
    case (state)
      IDLE:    pop_req = launch;
      SEND:    pop_req = 1'b1;
      DRAIN:   pop_req = 1'b1;
      default: pop_req = 1'b0;
    endcase
  end

  aec_char_fifo #(.DEPTH(DEPTH), .AW(AW), .DATA_W(8)) u_char_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Number of complete expressions currently buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt <= '0;
    end else if (fifo_flush) begin
      eq_cnt <= '0;
    end else begin
      case ({push_eq, pop_eq})
        2'b10:   eq_cnt <= eq_cnt + 1'b1;
        2'b01:   eq_cnt <= eq_cnt - 1'b1;
        default: eq_cnt <= eq_cnt;
      endcase
    end
  end

`ifdef AEC_FEED_LEN_CHECK_EN
  // Length of the expression being pushed; a side entry per '=' records
  // whether that expression exceeded the AEC buffer.
  logic [6:0] len_cnt;
  logic       ovs_head;
  logic       ovs_full;
  logic       ovs_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt <= '0;
    end else if (fifo_flush) begin
      len_cnt <= '0;
    end else if (fifo_push) begin
      if (in_data == ASCII_EQ)  len_cnt <= '0;
      else if (len_cnt != 7'h7f) len_cnt <= len_cnt + 1'b1;
    end
  end

  // len_cnt counts the bytes before '=', so bit 6 set means > 64 with '='.
  aec_char_fifo #(.DEPTH(DEPTH), .AW(AW), .DATA_W(1)) u_ovs_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (push_eq),
    .push_data (len_cnt[6]),
    .pop       (pop_eq),
    .head      (ovs_head),
    .full      (ovs_full),
    .empty     (ovs_empty)
  );
`endif

  // aec_ascii is registered together with aec_ready so the launch strobe and
  // the first character line up; it shows '=' (an AEC no-op) when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aec_ready <= 1'b0;
      aec_ascii <= ASCII_EQ;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      aec_ready <= 1'b0;
      aec_ascii <= ASCII_EQ;
      // A result raised early (during DRAIN) may be taken before REPORT.
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
`ifdef AEC_FEED_LEN_CHECK_EN
            if (ovs_head) begin
              res_data  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= head_is_eq ? REPORT : DRAIN;
            end else
`endif
            begin
              aec_ready <= 1'b1;
              aec_ascii <= head;
              // A lone '=' is complete after the launch byte itself.
              state     <= head_is_eq ? WAIT_FIN : SEND;
            end
          end else if (full && (eq_cnt == '0)) begin
            state <= OVF;
          end
        end
        SEND: begin
          if (aec_finish) begin
            res_data  <= aec_result;
            res_err   <= ~aec_valid;
            res_valid <= 1'b1;
            state     <= head_is_eq ? REPORT : DRAIN;
          end else begin
            aec_ascii <= head;
            if (head_is_eq) state <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          if (aec_finish) begin
            res_data  <= aec_result;
            res_err   <= ~aec_valid;
            res_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        DRAIN: begin
          if (head_is_eq) state <= REPORT;
        end
        OVF: begin
          if (in_valid && (in_data == ASCII_EQ)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (!res_valid || res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_feeder.sv
// tb_aec_feeder: directed bench for aec_feeder (DEPTH=8). A scripted AEC
// stand-in records forwarded characters and returns a chosen finish/result.
module tb_aec_feeder;

  localparam logic [7:0] EQ = 8'd61;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        aec_ready;
  logic [7:0]  aec_ascii;
  logic        aec_finish;
  logic [31:0] aec_result;
  logic        aec_valid;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  int vectors;
  int miscompares;

  logic [7:0]  sent_q[$];
  logic [7:0]  post_q[$];
  int          rdy_cnt;
  bit          serve_to;
  logic [31:0] got_d[$];
  logic        got_e[$];
  int          launch_cnt;

  aec_feeder #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .aec_ready  (aec_ready),
    .aec_ascii  (aec_ascii),
    .aec_finish (aec_finish),
    .aec_result (aec_result),
    .aec_valid  (aec_valid),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      got_d.push_back(res_data);
      got_e.push_back(res_err);
    end
    if (rst_n && aec_ready) launch_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push_str(input string s);
    int w;
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      in_valid = 1'b1;
      in_data  = c;
      w = 0;
      while (in_ready !== 1'b1 && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (in_ready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL push_timeout char %c in_ready=%b", c, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic aec_serve(input int early_n, input int lat, input logic [31:0] r, input logic v);
    int w;
    int n;
    serve_to = 1'b0;
    sent_q.delete();
    post_q.delete();
    rdy_cnt = 0;
    w = 0;
    while (aec_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (aec_ready !== 1'b1) begin
      serve_to = 1'b1;
      return;
    end
    n = 0;
    while (n < 80) begin
      sent_q.push_back(aec_ascii);
      if (aec_ready === 1'b1) rdy_cnt++;
      n++;
      if (aec_ascii == EQ || n == early_n) break;
      @(negedge clk);
    end
    repeat (lat) begin
      @(negedge clk);
      post_q.push_back(aec_ascii);
      if (aec_ready === 1'b1) rdy_cnt++;
    end
    aec_finish = 1'b1;
    aec_result = r;
    aec_valid  = v;
    @(negedge clk);
    aec_finish = 1'b0;
    aec_result = '0;
    aec_valid  = 1'b0;
    post_q.push_back(aec_ascii);
  endtask

  task automatic get_result(output logic [31:0] d, output logic e);
    int w;
    w = 0;
    while (got_d.size() == 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (got_d.size() == 0) begin
      d = 'x;
      e = 1'bx;
    end else begin
      d = got_d.pop_front();
      e = got_e.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    aec_finish = 1'b0; aec_result = '0; aec_valid = 1'b0; launch_cnt = 0;
    repeat (2) @(negedge clk);
    vectors += 6;
    if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    if (aec_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_aec_ready got %b want 0", aec_ready); end
    if (aec_ascii !== EQ)    begin miscompares++; $display("FAIL rst_aec_ascii got %0d want 61", aec_ascii); end
    if (res_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    if (res_data !== 32'd0)  begin miscompares++; $display("FAIL rst_res_data got %0d want 0", res_data); end
    if (res_err !== 1'b0)    begin miscompares++; $display("FAIL rst_res_err got %b want 0", res_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sends expression e, lets the AEC finish after lat idle cycles with result r.
  task automatic test_expr(input string e, input int lat, input logic [31:0] r);
    logic [31:0] d;
    logic        er;
    logic [7:0]  c;
    fork
      push_str(e);
      aec_serve(0, lat, r, 1'b1);
    join
    vectors += 3;
    if (serve_to) begin miscompares++; $display("FAIL %s launch_timeout", e); end
    if (rdy_cnt != 1) begin miscompares++; $display("FAIL %s aec_ready_cycles got %0d want 1", e, rdy_cnt); end
    if (sent_q.size() != e.len()) begin miscompares++; $display("FAIL %s sent_len got %0d want %0d", e, sent_q.size(), e.len()); end
    for (int i = 0; i < e.len() && i < sent_q.size(); i++) begin
      c = e[i];
      vectors++;
      if (sent_q[i] !== c) begin miscompares++; $display("FAIL %s sent[%0d] got %c want %c", e, i, sent_q[i], c); end
    end
    foreach (post_q[i]) begin
      vectors++;
      if (post_q[i] !== EQ) begin miscompares++; $display("FAIL %s idle_ascii[%0d] got %0d want 61", e, i, post_q[i]); end
    end
    get_result(d, er);
    vectors += 2;
    if (d !== r)     begin miscompares++; $display("FAIL %s res_data got %0d want %0d", e, d, r); end
    if (er !== 1'b0) begin miscompares++; $display("FAIL %s res_err got %b want 0", e, er); end
  endtask

  task automatic test_early_reject();
    logic [31:0] d;
    logic        er;
    fork
      push_str("1++2=5=");
      aec_serve(3, 0, 32'hDEAD_BEEF, 1'b0);
    join
    vectors += 5;
    if (serve_to || sent_q.size() != 3) begin miscompares++; $display("FAIL rej_sent_len got %0d want 3", sent_q.size()); end
    else if (sent_q[0] !== "1" || sent_q[1] !== "+" || sent_q[2] !== "+") begin
      miscompares++; $display("FAIL rej_sent got %c%c%c want 1++", sent_q[0], sent_q[1], sent_q[2]);
    end
    if (post_q[0] !== EQ) begin miscompares++; $display("FAIL rej_drain_ascii got %c want =", post_q[0]); end
    aec_serve(0, 0, 32'd5, 1'b1);
    if (serve_to || sent_q.size() != 2) begin miscompares++; $display("FAIL rej_next_len got %0d want 2", sent_q.size()); end
    else if (sent_q[0] !== "5" || sent_q[1] !== EQ) begin miscompares++; $display("FAIL rej_next got %c%c want 5=", sent_q[0], sent_q[1]); end
    if (rdy_cnt != 1) begin miscompares++; $display("FAIL rej_next_ready got %0d want 1", rdy_cnt); end
    get_result(d, er);
    vectors += 4;
    if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rej_res_data got %h want deadbeef", d); end
    if (er !== 1'b1)         begin miscompares++; $display("FAIL rej_res_err got %b want 1", er); end
    get_result(d, er);
    if (d !== 32'd5)         begin miscompares++; $display("FAIL rej2_res_data got %0d want 5", d); end
    if (er !== 1'b0)         begin miscompares++; $display("FAIL rej2_res_err got %b want 0", er); end
  endtask

  task automatic test_back_to_back_hold();
    logic [31:0] d;
    logic        er;
    @(posedge clk); #1 res_ready = 1'b0; @(negedge clk);
    fork
      push_str("1+2=");
      aec_serve(0, 0, 32'd3, 1'b1);
    join
    push_str("3=4+5=67");
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (res_valid !== 1'b1 || res_data !== 32'd3 || res_err !== 1'b0 || aec_ready !== 1'b0)
        begin miscompares++; $display("FAIL hold cyc%0d valid=%b data=%0d err=%b aec_ready=%b want 1/3/0/0", i, res_valid, res_data, res_err, aec_ready); end
      @(negedge clk);
    end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_full_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1 res_ready = 1'b1; @(negedge clk);
    get_result(d, er);
    vectors += 2;
    if (d !== 32'd3 || er !== 1'b0) begin miscompares++; $display("FAIL hold_res got %0d/%b want 3/0", d, er); end
    aec_serve(0, 0, 32'd3, 1'b1);
    get_result(d, er);
    if (d !== 32'd3 || er !== 1'b0 || sent_q.size() != 2) begin miscompares++; $display("FAIL b2b_first got %0d/%b len %0d want 3/0 len 2", d, er, sent_q.size()); end
    aec_serve(0, 0, 32'd9, 1'b1);
    get_result(d, er);
    vectors += 2;
    if (d !== 32'd9 || er !== 1'b0 || sent_q.size() != 4) begin miscompares++; $display("FAIL b2b_second got %0d/%b len %0d want 9/0 len 4", d, er, sent_q.size()); end
    fork
      push_str("=");
      aec_serve(0, 0, 32'd67, 1'b1);
    join
    get_result(d, er);
    if (d !== 32'd67 || er !== 1'b0 || sent_q.size() != 3) begin miscompares++; $display("FAIL b2b_third got %0d/%b len %0d want 67/0 len 3", d, er, sent_q.size()); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        er;
    int          l0;
    l0 = launch_cnt;
    push_str("0123456789");
    push_str("=");
    get_result(d, er);
    vectors += 3;
    if (launch_cnt != l0) begin miscompares++; $display("FAIL ovf_launches got %0d want 0", launch_cnt - l0); end
    if (d !== 32'd0)      begin miscompares++; $display("FAIL ovf_res_data got %0d want 0", d); end
    if (er !== 1'b1)      begin miscompares++; $display("FAIL ovf_res_err got %b want 1", er); end
    test_expr("2=", 0, 32'd2);
  endtask

  task automatic test_reset_mid();
    int w;
    push_str("1234567=");
    w = 0;
    while (aec_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (w >= 300)           begin miscompares++; $display("FAIL mid_launch_timeout"); end
    if (aec_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_aec_ready got %b want 0", aec_ready); end
    if (aec_ascii !== EQ)   begin miscompares++; $display("FAIL mid_rst_aec_ascii got %0d want 61", aec_ascii); end
    if (res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_res_valid got %b want 0", res_valid); end
    if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_expr("9=", 0, 32'd9);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_expr("1+2*3=", 0, 32'd7);
    test_expr("(a+3)*4=", 3, 32'd52);
    test_expr("=", 0, 32'd0);
    test_early_reject();
    test_back_to_back_hold();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
